// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game controller.
//   state_t        : FSM state enumeration, also driven out on the debug port
//   DEF_*          : default values for the game_ctrl parameters
//   timer_width()  : bit width needed by the frame timer for a pair of limits
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DEF_BALLS_INIT   = 3;
  localparam int DEF_SCORE_WIN    = 12;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_MISS_FRAMES  = 30;

  // ceil(log2(max(a, b) + 1)): enough bits to hold the larger terminal count.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame-tick pause timer.
//   clk, rst : system clock, asynchronous active-low reset
//   clear    : forces the count to zero (entry cycle of a pause)
//   en       : counting allowed; count is held at zero otherwise
//   tick     : one-cycle frame pulse to be counted
//   limit    : number of ticks making up the pause (>= 1)
//   done     : high in the cycle carrying the limit-th counted tick
module frame_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || !en) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end
  end

  // A tick landing on the clear cycle is not counted, so it cannot terminate.
  assign done = en && !clear && tick && (count == (limit - W'(1)));

endmodule

// File: rtl/game_ctrl.sv
// Game controller: sequences serve / play / miss pauses, keeps score and
// remaining balls, and reports game over.
//   clk, rst   : system clock, asynchronous active-low reset
//   start      : start button level (debounced)
//   hit, miss  : bar-hit / miss levels from the ball datapath
//   frame_tick : one-cycle pulse per video frame
//   play_en    : ball/bar motion enable, high only in PLAY
//   serve      : one-cycle pulse on the first cycle of every SERVE
//   score      : current score, saturating at 15
//   ball       : balls remaining, saturating at 0
//   over       : high exactly while in OVER
//   state      : current FSM state (state_t encoding)
// Handshake: none; start, hit and miss are levels and only their rising
// edges (against a one-cycle registered copy) cause any action.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int BALLS_INIT   = DEF_BALLS_INIT,
  parameter int SCORE_WIN    = DEF_SCORE_WIN,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES  = DEF_MISS_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       frame_tick,
  output logic       play_en,
  output logic       serve,
  output logic [3:0] score,
  output logic [1:0] ball,
  output logic       over,
  output logic [2:0] state
);

  localparam int TW = timer_width(SERVE_FRAMES, MISS_FRAMES);

  state_t       cur;
  logic         start_q, hit_q, miss_q;
  logic         start_edge, hit_edge, miss_edge;
  logic         entry;      // first cycle of SERVE or MISS: clears the timer
  logic         in_pause;
  logic [TW-1:0] limit;
  logic         pause_done;
  logic [3:0]   score_inc;
  logic [1:0]   ball_dec;

  assign start_edge = start && !start_q;
  assign hit_edge   = hit   && !hit_q;
  assign miss_edge  = miss  && !miss_q;

  assign in_pause = (cur == ST_SERVE) || (cur == ST_MISS);
  assign limit    = (cur == ST_SERVE) ? TW'(SERVE_FRAMES) : TW'(MISS_FRAMES);

  assign score_inc = (score == 4'd15) ? score : score + 4'd1;
  assign ball_dec  = (ball == 2'd0) ? ball : ball - 2'd1;

  frame_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (entry),
    .en    (in_pause),
    .tick  (frame_tick),
    .limit (limit),
    .done  (pause_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= ST_IDLE;
      start_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      entry   <= 1'b0;
      score   <= 4'd0;
      ball    <= 2'(BALLS_INIT);
      over    <= 1'b0;
      play_en <= 1'b0;
      serve   <= 1'b0;
    end else begin
      start_q <= start;
      hit_q   <= hit;
      miss_q  <= miss;
      serve   <= 1'b0;
      entry   <= 1'b0;
      case (cur)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            score <= 4'd0;
            ball  <= 2'(BALLS_INIT);
            over  <= 1'b0;
            cur   <= ST_SERVE;
            serve <= 1'b1;
            entry <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (pause_done) begin
            cur     <= ST_PLAY;
            play_en <= 1'b1;
          end
        end
        ST_PLAY: begin
          // A miss edge takes priority and swallows a coincident hit edge.
          if (miss_edge) begin
            ball    <= ball_dec;
            play_en <= 1'b0;
            if (ball_dec == 2'd0) begin
              cur  <= ST_OVER;
              over <= 1'b1;
            end else begin
              cur   <= ST_MISS;
              entry <= 1'b1;
            end
          end else if (hit_edge) begin
            score <= score_inc;
            if (score_inc == 4'(SCORE_WIN)) begin
              cur     <= ST_OVER;
              over    <= 1'b1;
              play_en <= 1'b0;
            end
          end
        end
        ST_MISS: begin
          if (pause_done) begin
            cur   <= ST_SERVE;
            serve <= 1'b1;
            entry <= 1'b1;
          end
        end
        default: begin
          cur     <= ST_IDLE;
          play_en <= 1'b0;
          over    <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed game scenarios plus a randomized phase, all
// checked every cycle against a behavioural game model.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  localparam int BI = 3;
  localparam int SW = 12;
  localparam int SF = 60;
  localparam int MF = 30;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start, hit, miss, frame_tick;
  logic       play_en, serve, over;
  logic [3:0] score;
  logic [1:0] ball;
  logic [2:0] state;

  always #5 clk = ~clk;

  game_ctrl #(
    .BALLS_INIT(BI), .SCORE_WIN(SW), .SERVE_FRAMES(SF), .MISS_FRAMES(MF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
    .frame_tick(frame_tick), .play_en(play_en), .serve(serve),
    .score(score), .ball(ball), .over(over), .state(state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // Pauses are modelled as "ticks still to wait"; the first cycle of a pause
  // never consumes a tick.
  state_t m_mode;
  int     m_score, m_ball, m_left;
  bit     m_serve, m_first;
  bit     p_start, p_hit, p_miss;

  task automatic model_reset();
    m_mode = ST_IDLE; m_score = 0; m_ball = BI; m_left = 0;
    m_serve = 0; m_first = 0;
    p_start = 0; p_hit = 0; p_miss = 0;
  endtask

  task automatic model_begin_serve();
    m_mode = ST_SERVE; m_serve = 1; m_left = SF; m_first = 1;
  endtask

  task automatic model_step(input bit s, input bit h, input bit m, input bit t);
    bit se, he, me;
    se = s && !p_start;
    he = h && !p_hit;
    me = m && !p_miss;
    m_serve = 0;
    case (m_mode)
      ST_IDLE, ST_OVER: begin
        if (se) begin
          m_score = 0; m_ball = BI;
          model_begin_serve();
        end
      end
      ST_SERVE, ST_MISS: begin
        if (m_first) m_first = 0;
        else if (t) begin
          m_left--;
          if (m_left == 0) begin
            if (m_mode == ST_SERVE) m_mode = ST_PLAY;
            else model_begin_serve();
          end
        end
      end
      ST_PLAY: begin
        if (me) begin
          m_ball = (m_ball > 0) ? m_ball - 1 : 0;
          if (m_ball == 0) m_mode = ST_OVER;
          else begin m_mode = ST_MISS; m_left = MF; m_first = 1; end
        end else if (he) begin
          m_score = (m_score < 15) ? m_score + 1 : 15;
          if (m_score == SW) m_mode = ST_OVER;
        end
      end
      default: m_mode = ST_IDLE;
    endcase
    p_start = s; p_hit = h; p_miss = m;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " state"},   32'(state),   32'(m_mode));
    check({tag, " score"},   32'(score),   32'(m_score));
    check({tag, " ball"},    32'(ball),    32'(m_ball));
    check({tag, " over"},    32'(over),    32'(m_mode == ST_OVER));
    check({tag, " play_en"}, 32'(play_en), 32'(m_mode == ST_PLAY));
    check({tag, " serve"},   32'(serve),   32'(m_serve));
  endtask

  // ---------------- driver tasks ----------------
  logic [2:0] cur_state, prv_state;
  int         serve_cnt = 0;

  task automatic step(input bit s, input bit h, input bit m, input bit t);
    start = s; hit = h; miss = m; frame_tick = t;
    @(posedge clk);
    model_step(s, h, m, t);
    #1;
    prv_state = cur_state;
    cur_state = state;
    if (serve) serve_cnt++;
    compare_all("cyc");
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    repeat (n) begin
      @(posedge clk); #1;
      compare_all("rst_hold");
    end
    rst = 1'b1;
    #1;
    compare_all("rst_rel");
    cur_state = state;
    prv_state = state;
  endtask

  // Runs a SERVE/MISS pause (possibly MISS then SERVE) with random ticks and
  // noise on start/hit/miss, measuring how many ticks each pause took.
  task automatic run_pause(input string tag);
    int cnt = 0;
    int n = 0;
    logic [2:0] old;
    bit s, h, m, t;
    while ((cur_state == ST_SERVE || cur_state == ST_MISS) && n < 2000) begin
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 3) == 0);
      if (cur_state != prv_state) cnt = 0;
      else if (t) cnt++;
      old = cur_state;
      step(s, h, m, t);
      n++;
      if (cur_state != old) begin
        if (old == ST_SERVE) check({tag, " serve_ticks"}, 32'(cnt), 32'(SF));
        else if (old == ST_MISS) check({tag, " miss_ticks"}, 32'(cnt), 32'(MF));
      end
    end
    if (n >= 2000) check({tag, " pause_timeout"}, 32'(0), 32'(1));
    step(0, 0, 0, 0);
  endtask

  task automatic hit_pulse();
    step(0, 1, 0, 1'($urandom_range(0, 1)));
    step(0, 0, 0, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; start = 0; hit = 0; miss = 0; frame_tick = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("init_rst");
    check("init ball", 32'(ball), 32'(BI));
    rst = 1'b1;
    #1;
    compare_all("init_rel");
    cur_state = state;
    prv_state = state;

    // Start, serve pause, into PLAY.
    serve_cnt = 0;
    step(1, 0, 0, 0);
    check("r38 serve_on_entry", 32'(serve), 32'(1));
    step(0, 0, 0, 0);
    run_pause("r38");
    check("r38 serve_count", 32'(serve_cnt), 32'(1));
    check("r38 play_en", 32'(play_en), 32'(1));
    check("r38 score", 32'(score), 32'(0));
    check("r38 ball", 32'(ball), 32'(3));

    // Hit held for 5 cycles counts once.
    repeat (5) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("r39 score", 32'(score), 32'(1));

    // Climb to 11, then simultaneous hit+miss.
    repeat (10) hit_pulse();
    check("r41 pre_score", 32'(score), 32'(11));
    step(0, 1, 1, 0);
    check("r41 score", 32'(score), 32'(11));
    check("r41 ball", 32'(ball), 32'(2));
    check("r41 state", 32'(state), 32'(ST_MISS));
    run_pause("r41");

    // Winning hit, then restart.
    step(0, 1, 0, 0);
    check("r42 score", 32'(score), 32'(12));
    check("r42 over", 32'(over), 32'(1));
    step(0, 0, 0, 0);
    serve_cnt = 0;
    step(1, 0, 0, 0);
    check("r42 score_reload", 32'(score), 32'(0));
    check("r42 ball_reload", 32'(ball), 32'(3));
    check("r42 serve", 32'(serve), 32'(1));
    step(0, 0, 0, 0);
    run_pause("r42");
    check("r42 serve_count", 32'(serve_cnt), 32'(1));

    // Three misses to game over.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      check("r40 ball", 32'(ball), 32'(2 - i));
      if (i < 2) begin
        check("r40 state_miss", 32'(state), 32'(ST_MISS));
        run_pause("r40");
      end else begin
        check("r40 over", 32'(over), 32'(1));
        check("r40 play_en", 32'(play_en), 32'(0));
        step(0, 0, 0, 0);
      end
    end

    // Randomized play.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1) == 0));
    end

    // Reset mid-MISS with 10 ticks counted; start held across release.
    apply_reset(2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    run_pause("r43pre");
    step(0, 0, 1, 0);
    check("r43 in_miss", 32'(state), 32'(ST_MISS));
    step(0, 0, 0, 0);
    repeat (10) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    start = 1'b1;
    apply_reset(3);
    check("r43 state", 32'(state), 32'(ST_IDLE));
    check("r43 serve", 32'(serve), 32'(0));
    step(1, 0, 0, 0);
    check("r35 start_edge_serve", 32'(serve), 32'(1));
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter BALLS_INIT, default 3, meaning balls (lives) at game start; legal range 1..3.
REQ-002 SHALL have parameter SCORE_WIN, default 12, meaning score that ends the game as a win; legal range 1..15.
REQ-003 SHALL have parameter SERVE_FRAMES, default 60, meaning frame ticks of pause before play resumes after a serve.
REQ-004 SHALL have parameter MISS_FRAMES, default 30, meaning frame ticks of pause after a non-final miss.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port start  input  1  player start button, level, already debounced.
REQ-008 SHALL have port hit  input  1  bar-hit flag from the ball/bar datapath, level, may stay high for several cycles.
REQ-009 SHALL have port miss  input  1  miss flag from the ball/bar datapath, level, may stay high for several cycles.
REQ-010 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 SHALL have port play_en  output  1  enables ball/bar motion in the datapath.
REQ-012 SHALL have port serve  output  1  one-cycle pulse ordering the datapath to re-centre the ball.
REQ-013 SHALL have port score  output  4  current score.
REQ-014 SHALL have port ball  output  2  balls remaining.
REQ-015 SHALL have port over  output  1  game finished (win or loss).
REQ-016 SHALL have port state  output  3  current FSM state encoding, for debug and display.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE, PLAY, MISS, OVER; all outputs are registered.
REQ-018 SHALL act on hit, miss, and start only at their rising edges, detected against a one-cycle registered copy of each signal.
REQ-019 IDLE: on a start edge SHALL load score=0 and ball=BALLS_INIT, then go to SERVE.
REQ-020 On every entry to SERVE, serve SHALL pulse high for exactly the first cycle in SERVE.
REQ-021 SERVE and MISS: frame-tick counter SHALL clear on the entry cycle and count only ticks after entry.
REQ-022 SERVE SHALL go to PLAY in the cycle after the SERVE_FRAMES-th counted tick.
REQ-023 MISS SHALL go to SERVE in the cycle after the MISS_FRAMES-th counted tick.
REQ-024 play_en SHALL be 1 only in PLAY.
REQ-025 PLAY, hit edge only: score increments by 1; if the new score equals SCORE_WIN, go to OVER, else stay in PLAY.
REQ-026 PLAY, miss edge: ball decrements by 1; if the new value is 0, go to OVER, else go to MISS.
REQ-027 Simultaneous hit and miss edges in PLAY: miss SHALL win and the hit SHALL be discarded.
REQ-028 hit and miss edges outside PLAY SHALL be ignored; score and ball are unchanged.
REQ-029 score SHALL saturate at 15 and ball SHALL saturate at 0; neither wraps.
REQ-030 over SHALL be 1 exactly while in OVER.
REQ-031 OVER: a start edge SHALL reload score and ball (as in IDLE) and go directly to SERVE.
REQ-032 start edges in SERVE, PLAY, and MISS SHALL be ignored.

Reset
REQ-033 While rst=0, the block SHALL hold: state=IDLE, score=0, ball=BALLS_INIT, over=0, play_en=0, serve=0, counters=0, edge registers=0.
REQ-034 Reset mid-game SHALL abort immediately with no serve pulse; the first cycle after release SHALL be IDLE.
REQ-035 Because the edge registers reset to 0, a start held high across reset release SHALL count as an edge.

Structure
REQ-036 A shared package SHALL hold the state enumeration and the default constants BALLS_INIT, SCORE_WIN, SERVE_FRAMES, and MISS_FRAMES.
REQ-037 The frame counter SHALL be one sub-module, frame_timer (clear, tick, terminal-count compare), sized to ceil(log2(max(SERVE_FRAMES, MISS_FRAMES)+1)) bits.

Verification
REQ-038 Bench SHALL cover: reset, start edge, then 60 frame ticks -> serve pulses once on SERVE entry; play_en rises after the 60th tick; score=0, ball=3.
REQ-039 Bench SHALL cover: PLAY, hit held high 5 cycles -> score increments once, to 1.
REQ-040 Bench SHALL cover: PLAY with 3 miss edges, each followed by its pause -> ball 3→2→1→0; the third miss gives over=1 and play_en=0.
REQ-041 Bench SHALL cover: score=11, hit and miss edges in the same cycle -> score stays 11, ball decrements, state=MISS.
REQ-042 Bench SHALL cover: score=11, hit edge -> score=12, over=1; then start edge -> score=0, ball=3, one serve pulse.
REQ-043 Bench SHALL cover: rst driven low during MISS with frame counter at 10 -> outputs at their reset values, state=IDLE, no serve pulse.
